// File: rtl/pipe_hazard_ctrl.sv
// Decode-side pipeline sequencing for the five-stage MIPS core: load-use and
// HI/LO stalls, taken-branch bubbles, and the CP0 exception/eret flush FSM.
module pipe_hazard_ctrl #(
  parameter int MUL_LAT      = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       id_valid,
  input  logic [4:0] id_Ra,
  input  logic [4:0] id_Rb,
  input  logic       id_useRa,
  input  logic       id_useRb,
  input  logic       id_mulCtr,
  input  logic       id_mulRead,
  input  logic       ex_valid,
  input  logic [4:0] ex_Rw,
  input  logic [1:0] ex_MemRead,
  input  logic       ex_mulCtr,
  input  logic       ex_branchTaken,
  input  logic [2:0] ex_cp0Op,
  output logic       hazard,
  output logic       BranchBubble,
  output logic       cp0Bubble,
  output logic       pc_stall,
  output logic       ifid_flush,
  output logic       epc_redirect,
  output logic       mul_busy
);

  localparam int CNT_W = $clog2(MUL_LAT);
  localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t           state;
  logic [FC_W-1:0]  fc;
  logic [CNT_W-1:0] cnt;

  logic trig;
  logic flush_active;
  logic lu;
  logic ms;
  logic busy;
  logic branch_bubble;
  logic stall;

  assign trig         = ex_valid && (ex_cp0Op == 3'b100 || ex_cp0Op == 3'b101);
  assign flush_active = (trig && state == IDLE) || state == FLUSH;

  assign lu = id_valid && ex_valid && (ex_MemRead != 2'b00) && (ex_Rw != 5'd0) &&
              ((id_useRa && id_Ra == ex_Rw) || (id_useRb && id_Rb == ex_Rw));

  assign busy = (cnt != '0);
  assign ms   = id_valid && (id_mulRead || id_mulCtr) && (busy || (ex_valid && ex_mulCtr));

  // Priority: flush overrides branch, branch overrides any stall.
  assign branch_bubble = ex_branchTaken && !flush_active;
  assign stall         = (lu || ms) && !flush_active && !ex_branchTaken;

  // Outputs are forced low while Rst is high so nothing escapes before state is known.
  assign cp0Bubble    = !Rst && flush_active;
  assign epc_redirect = !Rst && trig && state == IDLE;
  assign BranchBubble = !Rst && branch_bubble;
  assign hazard       = !Rst && stall;
  assign pc_stall     = !Rst && stall;
  assign ifid_flush   = !Rst && (flush_active || branch_bubble);
  assign mul_busy     = !Rst && busy;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      fc    <= '0;
    end else begin
      case (state)
        IDLE: if (trig) begin
          state <= FLUSH;
          fc    <= FC_W'(FLUSH_CYCLES - 1);
        end
        FLUSH: begin
          if (fc == '0) state <= IDLE;
          else          fc    <= fc - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // HI/LO is architectural, so the count keeps running through a flush;
  // only a new multiply issue is suppressed while flushing.
  always_ff @(posedge Clk) begin
    if (Rst)                                      cnt <= '0;
    else if (ex_valid && ex_mulCtr && !flush_active) cnt <= CNT_W'(MUL_LAT - 1);
    else if (cnt != '0)                           cnt <= cnt - 1'b1;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: single-cycle vector table plus
// multi-cycle sequences for multiply, flush and reset corner cases.
module tb_pipe_hazard_ctrl;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       id_valid, id_useRa, id_useRb, id_mulCtr, id_mulRead;
  logic [4:0] id_Ra, id_Rb, ex_Rw;
  logic       ex_valid, ex_mulCtr, ex_branchTaken;
  logic [1:0] ex_MemRead;
  logic [2:0] ex_cp0Op;
  logic       hazard, BranchBubble, cp0Bubble, pc_stall, ifid_flush, epc_redirect, mul_busy;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_hazard_ctrl #(.MUL_LAT(32), .FLUSH_CYCLES(2)) dut (
    .Clk(Clk), .Rst(Rst),
    .id_valid(id_valid), .id_Ra(id_Ra), .id_Rb(id_Rb),
    .id_useRa(id_useRa), .id_useRb(id_useRb),
    .id_mulCtr(id_mulCtr), .id_mulRead(id_mulRead),
    .ex_valid(ex_valid), .ex_Rw(ex_Rw), .ex_MemRead(ex_MemRead),
    .ex_mulCtr(ex_mulCtr), .ex_branchTaken(ex_branchTaken), .ex_cp0Op(ex_cp0Op),
    .hazard(hazard), .BranchBubble(BranchBubble), .cp0Bubble(cp0Bubble),
    .pc_stall(pc_stall), .ifid_flush(ifid_flush), .epc_redirect(epc_redirect),
    .mul_busy(mul_busy)
  );

  always #5 Clk = ~Clk;

  // Expected-output packing: {hazard, BranchBubble, cp0Bubble, pc_stall, ifid_flush, epc_redirect, mul_busy}
  typedef struct {
    string      name;
    logic       idv;
    logic [4:0] ra, rb;
    logic       ua, ub, imc, imr, exv;
    logic [4:0] rw;
    logic [1:0] mr;
    logic       emc, ebt;
    logic [2:0] cop;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic idv, logic [4:0] ra, logic [4:0] rb,
                              logic ua, logic ub, logic imc, logic imr, logic exv,
                              logic [4:0] rw, logic [1:0] mr, logic emc, logic ebt,
                              logic [2:0] cop, logic [6:0] exp);
    vec_t v;
    v.name = n; v.idv = idv; v.ra = ra; v.rb = rb; v.ua = ua; v.ub = ub;
    v.imc = imc; v.imr = imr; v.exv = exv; v.rw = rw; v.mr = mr;
    v.emc = emc; v.ebt = ebt; v.cop = cop; v.exp = exp;
    return v;
  endfunction

  function automatic logic [6:0] outs();
    return {hazard, BranchBubble, cp0Bubble, pc_stall, ifid_flush, epc_redirect, mul_busy};
  endfunction

  task automatic check(string name, logic [6:0] act, logic [6:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check1(string name, logic act, logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_Ra = 0; id_Rb = 0; id_useRa = 0; id_useRb = 0;
    id_mulCtr = 0; id_mulRead = 0; ex_valid = 0; ex_Rw = 0; ex_MemRead = 0;
    ex_mulCtr = 0; ex_branchTaken = 0; ex_cp0Op = 0;
  endtask

  task automatic apply(vec_t v);
    id_valid = v.idv; id_Ra = v.ra; id_Rb = v.rb; id_useRa = v.ua; id_useRb = v.ub;
    id_mulCtr = v.imc; id_mulRead = v.imr; ex_valid = v.exv; ex_Rw = v.rw;
    ex_MemRead = v.mr; ex_mulCtr = v.emc; ex_branchTaken = v.ebt; ex_cp0Op = v.cop;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    idle_inputs();
    tick();
    Rst = 1'b0;
  endtask

  initial begin
    //            name          idv ra  rb  ua ub imc imr exv rw  mr   emc ebt cop     exp
    vecs.push_back(mk("lu_ra",     1, 8,  0, 1, 0, 0, 0, 1, 8, 2'd1, 0, 0, 3'b000, 7'b1001000));
    vecs.push_back(mk("lu_rw0",    1, 0,  0, 1, 0, 0, 0, 1, 0, 2'd1, 0, 0, 3'b000, 7'b0000000));
    vecs.push_back(mk("lu_rb",     1, 3,  9, 1, 1, 0, 0, 1, 9, 2'd2, 0, 0, 3'b000, 7'b1001000));
    vecs.push_back(mk("lu_nouse",  1, 8,  0, 0, 0, 0, 0, 1, 8, 2'd1, 0, 0, 3'b000, 7'b0000000));
    vecs.push_back(mk("lu_noload", 1, 8,  0, 1, 0, 0, 0, 1, 8, 2'd0, 0, 0, 3'b000, 7'b0000000));
    vecs.push_back(mk("lu_exinv",  1, 8,  0, 1, 0, 0, 0, 0, 8, 2'd1, 0, 0, 3'b000, 7'b0000000));
    vecs.push_back(mk("lu_idinv",  0, 8,  0, 1, 0, 0, 0, 1, 8, 2'd1, 0, 0, 3'b000, 7'b0000000));
    vecs.push_back(mk("br_over_lu",1, 8,  0, 1, 0, 0, 0, 1, 8, 2'd1, 0, 1, 3'b000, 7'b0100100));
    vecs.push_back(mk("ms_ex_mul", 1, 0,  0, 0, 0, 0, 1, 1, 0, 2'd0, 1, 0, 3'b000, 7'b1001000));
    vecs.push_back(mk("ms_mul_mul",1, 0,  0, 0, 0, 1, 0, 1, 0, 2'd0, 1, 0, 3'b000, 7'b1001000));
    vecs.push_back(mk("ms_nomul",  1, 0,  0, 0, 0, 0, 1, 1, 0, 2'd0, 0, 0, 3'b000, 7'b0000000));
    vecs.push_back(mk("exc_all",   1, 8,  0, 1, 0, 0, 0, 1, 8, 2'd1, 0, 1, 3'b100, 7'b0010110));
    vecs.push_back(mk("eret",      0, 0,  0, 0, 0, 0, 0, 1, 0, 2'd0, 0, 0, 3'b101, 7'b0010110));
    vecs.push_back(mk("cp0_other", 0, 0,  0, 0, 0, 0, 0, 1, 0, 2'd0, 0, 0, 3'b110, 7'b0000000));
    vecs.push_back(mk("cp0_exinv", 0, 0,  0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 1, 3'b100, 7'b0100100));

    // Reset with every input high: all outputs held low.
    Rst = 1'b1;
    id_valid = 1; id_Ra = 5'd31; id_Rb = 5'd31; id_useRa = 1; id_useRb = 1;
    id_mulCtr = 1; id_mulRead = 1; ex_valid = 1; ex_Rw = 5'd31; ex_MemRead = 2'b11;
    ex_mulCtr = 1; ex_branchTaken = 1; ex_cp0Op = 3'b111;
    tick();
    check("rst_all_ones_a", outs(), 7'b0);
    ex_cp0Op = 3'b100;
    #1 check("rst_all_ones_b", outs(), 7'b0);
    tick();
    check("rst_all_ones_c", outs(), 7'b0);
    Rst = 1'b0;
    idle_inputs();
    #1 check("post_rst_idle", outs(), 7'b0);
    tick();
    check("post_rst_idle2", outs(), 7'b0);

    // Single-cycle vectors, each from a fresh reset.
    foreach (vecs[i]) begin
      do_reset();
      apply(vecs[i]);
      #1 check(vecs[i].name, outs(), vecs[i].exp);
    end

    // Load-use: one stall cycle, then the bubble in EX clears it.
    do_reset();
    id_valid = 1; id_Ra = 8; id_useRa = 1; ex_valid = 1; ex_Rw = 8; ex_MemRead = 2'd1;
    #1 check("lu_seq_c0", outs(), 7'b1001000);
    tick();
    ex_valid = 0; ex_Rw = 0; ex_MemRead = 0;
    #1 check("lu_seq_c1", outs(), 7'b0000000);

    // Multiply in EX at T with mfhi in ID: stalled T..T+31, released at T+32.
    do_reset();
    id_valid = 1; id_mulRead = 1; ex_valid = 1; ex_mulCtr = 1;
    for (int k = 0; k < 32; k++) begin
      #1;
      check1($sformatf("mul_hazard_t%0d", k), hazard, 1'b1);
      check1($sformatf("mul_busy_t%0d", k), mul_busy, k != 0);
      tick();
      ex_valid = 0; ex_mulCtr = 0;
    end
    #1;
    check("mul_release", outs(), 7'b0000000);

    // Exception with branch and load-use present; retriggers during FLUSH are ignored.
    do_reset();
    id_valid = 1; id_Ra = 8; id_useRa = 1; ex_valid = 1; ex_Rw = 8; ex_MemRead = 2'd1;
    ex_branchTaken = 1; ex_cp0Op = 3'b100; ex_mulCtr = 1;
    #1 check("exc_t0", outs(), 7'b0010110);
    tick();
    #1 check("exc_t1", outs(), 7'b0010100);
    tick();
    ex_cp0Op = 3'b101;
    #1 check("exc_t2", outs(), 7'b0010100);
    tick();
    ex_cp0Op = 3'b000; ex_mulCtr = 0;
    #1 check("exc_t3", outs(), 7'b0100100);
    ex_branchTaken = 0; ex_valid = 0;
    #1 check("exc_t3_quiet", outs(), 7'b0000000);

    // Reset 15 cycles into a multiply clears the busy window.
    do_reset();
    ex_valid = 1; ex_mulCtr = 1;
    tick();
    idle_inputs();
    for (int k = 1; k < 15; k++) tick();
    #1 check1("mid_mul_busy", mul_busy, 1'b1);
    Rst = 1'b1;
    #1 check("mid_mul_rst", outs(), 7'b0);
    tick();
    Rst = 1'b0;
    #1 check1("mid_mul_busy_clr", mul_busy, 1'b0);
    id_valid = 1; id_mulRead = 1;
    #1 check("mid_mul_mfhi_free", outs(), 7'b0000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the five-stage MIPS core. It drives the stall and bubble controls of the IF/ID and ID/EX pipeline registers: `hazard`, `BranchBubble` and `cp0Bubble`. It detects load-use hazards and tracks the iterative multiplier's busy window so HI/LO accesses stall correctly. It also runs a flush state machine for CP0 exceptions and `eret`. It sits beside the decode stage and consumes ID-stage and EX-stage control fields.

## Interface
Parameters:
- `MUL_LAT`, default 32: multiplier latency in cycles, from EX issue to HI/LO valid; must be ≥ 2.
- `FLUSH_CYCLES`, default 2: number of cycles `cp0Bubble` is held after a CP0 trigger; must be ≥ 1.

Ports:
- `Clk`  in  1  clock; all state updates on rising edge.
- `Rst`  in  1  reset, synchronous, active-high.
- `id_valid`  in  1  ID stage holds a real instruction.
- `id_Ra`, `id_Rb`  in  5  ID source register numbers.
- `id_useRa`, `id_useRb`  in  1  ID instruction actually reads Ra / Rb.
- `id_mulCtr`  in  1  ID instruction starts a multiply.
- `id_mulRead`  in  1  ID instruction reads HI/LO.
- `ex_valid`  in  1  EX stage holds a real instruction.
- `ex_Rw`  in  5  EX destination register.
- `ex_MemRead`  in  2  EX load type; nonzero means the instruction is a load.
- `ex_mulCtr`  in  1  EX instruction is a multiply.
- `ex_branchTaken`  in  1  branch resolved taken in EX.
- `ex_cp0Op`  in  3  EX CP0 op: 3'b100 = exception/syscall, 3'b101 = eret; other values are not triggers.
- `hazard`  out  1  stall PC and IF/ID; bubble into ID/EX.
- `BranchBubble`  out  1  bubble into ID/EX and flush IF/ID.
- `cp0Bubble`  out  1  bubble into ID/EX during the exception flush.
- `pc_stall`  out  1  hold the PC.
- `ifid_flush`  out  1  zero IF/ID.
- `epc_redirect`  out  1  one-cycle pulse selecting the EPC/vector PC.
- `mul_busy`  out  1  multiplier occupied.

## Operation
- **Load-use (`lu`)** asserts when all of the following hold:
  - `id_valid && ex_valid && ex_MemRead != 0 && ex_Rw != 0`
  - and at least one source matches: `(id_useRa && id_Ra == ex_Rw) || (id_useRb && id_Rb == ex_Rw)`.
- **Multiplier counter:**
  - Width is `$clog2(MUL_LAT)`.
  - Loads `MUL_LAT-1` on a cycle with `ex_valid && ex_mulCtr && !flush_active`.
  - Otherwise it decrements while nonzero and saturates at 0.
  - `mul_busy = (cnt != 0)`.
- **Multiplier stall (`ms`)** asserts when `id_valid && (id_mulRead || id_mulCtr) && (mul_busy || (ex_valid && ex_mulCtr))`.
- **Flush FSM** has two states, IDLE and FLUSH, with a down-counter `fc`.
  - IDLE → FLUSH when `trig = ex_valid && ex_cp0Op ∈ {100, 101}`. On that edge, `fc` loads `FLUSH_CYCLES-1`.
  - In FLUSH, `fc` decrements each cycle. The FSM returns to IDLE on the cycle `fc == 0`.
  - `flush_active = trig (in IDLE) || state == FLUSH`.
- **Outputs:** all combinational from the current state and inputs. Priority is flush > branch > stall.
  - `cp0Bubble = flush_active`
  - `epc_redirect = trig && state == IDLE`
  - `BranchBubble = ex_branchTaken && !flush_active`
  - `hazard = (lu || ms) && !flush_active && !ex_branchTaken`
  - `pc_stall = hazard`
  - `ifid_flush = flush_active || BranchBubble`
- `trig` seen while already in FLUSH is ignored; the FSM does not restart.
- The multiplier counter keeps running through a flush, because HI/LO is architectural. Only a new multiply load is blocked during a flush.

## Timing
- **Reset** (`Rst` high at a rising edge):
  - State = IDLE, `fc = 0`, `cnt = 0`.
  - While `Rst` is high, every output is 0, regardless of inputs.
- **Load-use:** exactly 1 stall cycle. The bubble moves the load to MEM, which clears `lu` on the next cycle.
- **Multiply:** the multiply is in EX at cycle T. A dependent HI/LO reader in ID is stalled in cycles T … T+MUL_LAT-1 and released at T+MUL_LAT.
- **CP0 trigger:**
  - Trigger at cycle T: `cp0Bubble` is high for cycles T … T+FLUSH_CYCLES.
  - `epc_redirect` pulses only at T.
- **Reset mid-operation:** aborts any multiply count or flush in the same edge. No output glitch after reset deassertion.

## Test plan
- Reset with all inputs at 1 → all outputs 0. After release with idle inputs → `mul_busy = 0` and state IDLE.
- Load-use: EX `lw` with `ex_Rw = 8`; ID `add` with `id_Ra = 8`, `id_useRa = 1` → `hazard = pc_stall = 1` for 1 cycle, then 0. Same test with `ex_Rw = 0` → no stall.
- Multiply then `mfhi`, with `MUL_LAT = 32`: `mult` in EX at cycle 10, `mfhi` in ID from cycle 10 → `hazard` high for cycles 10–41, low at 42. `mul_busy` is low at cycle 42.
- Branch: `ex_branchTaken = 1` together with a load-use condition → `BranchBubble = 1`, `ifid_flush = 1`, `hazard = 0`.
- Exception with `ex_cp0Op = 3'b100` while branch and load-use are also asserted, `FLUSH_CYCLES = 2`:
  - `cp0Bubble` high for 3 cycles.
  - `epc_redirect` high for 1 cycle.
  - `BranchBubble = 0` and `hazard = 0` throughout.
  - A second trigger during FLUSH does not extend the flush.
- `Rst` pulsed at cycle 15 of a 32-cycle multiply → `mul_busy = 0` on the next cycle. A following `mfhi` is not stalled.
